// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_A2B = 4'b1000;  // a + 2b - 4
  localparam logic [3:0] ALU_B2A = 4'b1001;  // b + 2a
  localparam logic [3:0] ALU_MUL = 4'b1010;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StMul   = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL);
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: exactly XLEN steps after start, low XLEN product bits.
// Instantiated by seq_alu only when SEQ_ALU_MUL_EN is defined.
module seq_alu_mul #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] p
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  logic             busy_q;
  logic [XLEN-1:0]  mcand_q, mplier_q, prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  prod_nxt;

  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
  // Final step's partial sum is handed out combinationally so done lands on step XLEN.
  assign done     = busy_q && (cnt_q == CNT_W'(1));
  assign p        = prod_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      mcand_q  <= a;
      mplier_q <= b;
      prod_q   <= '0;
      cnt_q    <= CNT_W'(XLEN);
    end else if (busy_q) begin
      prod_q   <= prod_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake, registered y/zero and a bit-serial shifter.
// Define SEQ_ALU_MUL_EN to enable the iterative multiply on code 1010 (else it decodes as SLT).
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]    y_q, y_d;
  logic               zero_q, zero_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shl_q, shl_d;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    comb_res;

  assign shamt = b[SHAMT_W-1:0];

`ifdef SEQ_ALU_MUL_EN
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_res;

  seq_alu_mul #(
    .XLEN (XLEN)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_res)
  );
`endif

  // Single-cycle results; shifts only reach this mux with a zero shift amount.
  always_comb begin
    comb_res = '0;
    case (ctrl)
      ALU_AND: comb_res = a & b;
      ALU_OR:  comb_res = a | b;
      ALU_ADD: comb_res = a + b;
      ALU_SUB: comb_res = a - b;
      ALU_A2B: comb_res = a + (b << 1) - XLEN'(4);
      ALU_B2A: comb_res = b + (a << 1);
      ALU_SLL: comb_res = a;
      ALU_SRL: comb_res = a;
      default: comb_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    shl_d     = shl_q;
    y_d       = y_q;
    zero_d    = zero_q;
`ifdef SEQ_ALU_MUL_EN
    mul_start = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_shift(ctrl) && (shamt != '0)) begin
            acc_d   = a;
            cnt_d   = shamt;
            shl_d   = (ctrl == ALU_SLL);
            state_d = StShift;
          end
`ifdef SEQ_ALU_MUL_EN
          else if (ctrl == ALU_MUL) begin
            mul_start = 1'b1;
            state_d   = StMul;
          end
`endif
          else begin
            y_d     = comb_res;
            zero_d  = (comb_res == '0);
            state_d = StDone;
          end
        end
      end
      StShift: begin
        acc_d = shl_q ? (acc_q << 1) : (acc_q >> 1);
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          y_d     = acc_d;
          zero_d  = (acc_d == '0);
          state_d = StDone;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      StMul: begin
        if (mul_done) begin
          y_d     = mul_res;
          zero_d  = (mul_res == '0);
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign y         = y_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, handshake corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_seq_alu;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      ctrl;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] y;
  logic            zero;

  int checks = 0;
  int errors = 0;

  seq_alu #(
    .XLEN (XLEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] y;
    int              lat;
  } vec_t;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model_y(input logic [3:0] c, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] z);
    int sh;
    logic [XLEN-1:0] slt;
    sh  = int'(z[5:0]);
    slt = ($signed(x) < $signed(z)) ? 64'd1 : 64'd0;
    case (c)
      4'd0:    return x & z;
      4'd1:    return x | z;
      4'd2:    return x + z;
      4'd3:    return x << sh;
      4'd4:    return x >> sh;
      4'd6:    return x - z;
      4'd8:    return x + 2 * z - 4;
      4'd9:    return z + 2 * x;
`ifdef SEQ_ALU_MUL_EN
      4'd10:   return x * z;
`endif
      default: return slt;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [XLEN-1:0] z);
    int sh;
    sh = int'(z[5:0]);
    if ((c == 4'd3 || c == 4'd4) && sh != 0) return sh + 1;
`ifdef SEQ_ALU_MUL_EN
    if (c == 4'd10) return XLEN + 1;
`endif
    return 1;
  endfunction

  // Issues one op, waits for the result, then pops it; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [3:0] c, input logic [XLEN-1:0] aa, input logic [XLEN-1:0] bb,
                        output logic [XLEN-1:0] yy, output logic zz, output int lat,
                        output logic timed_out);
    int w;
    timed_out = 1'b0;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) timed_out = 1'b1;
    ctrl     = c;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Operands must have been captured at accept.
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    yy        = y;
    zz        = zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_check(input string name, input logic [3:0] c, input logic [XLEN-1:0] aa,
                          input logic [XLEN-1:0] bb, input logic [XLEN-1:0] ey, input int elat);
    logic [XLEN-1:0] yy;
    logic            zz;
    int              lat;
    logic            to;
    run_op(c, aa, bb, yy, zz, lat, to);
    check({name, " y"}, yy, ey);
    check({name, " zero"}, XLEN'(zz), XLEN'(ey == '0));
    check({name, " latency"}, XLEN'(lat), XLEN'(elat));
    check({name, " timeout"}, XLEN'(to), '0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0]      rc;
    logic [XLEN-1:0] ra, rb;
    int              n;

    vecs.push_back('{"add", 4'b0010, 64'd5, 64'd7, 64'd12, 1});
    vecs.push_back('{"sub_zero", 4'b0110, 64'd9, 64'd9, 64'd0, 1});
    vecs.push_back('{"and", 4'b0000, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_00F0,
                     64'h00F0_0000_00FF_0030, 1});
    vecs.push_back('{"or", 4'b0001, 64'hF000_0000_0000_0001, 64'h000F_0000_0000_0010,
                     64'hF00F_0000_0000_0011, 1});
    vecs.push_back('{"slt_neg1", 4'b0111, '1, 64'd1, 64'd1, 1});
    vecs.push_back('{"slt_ovf", 4'b1111, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 1});
    vecs.push_back('{"slt_false", 4'b0101, 64'd1, '1, 64'd0, 1});
    vecs.push_back('{"slt_negs", 4'b1011, -64'sd5, -64'sd2, 64'd1, 1});
    vecs.push_back('{"sll3", 4'b0011, 64'd1, 64'd67, 64'd8, 4});
    vecs.push_back('{"srl63", 4'b0100, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 64});
    vecs.push_back('{"srl0", 4'b0100, 64'hDEAD_BEEF_0000_0001, 64'd64, 64'hDEAD_BEEF_0000_0001, 1});
    vecs.push_back('{"a2b", 4'b1000, 64'd1, 64'd1, '1, 1});
    vecs.push_back('{"b2a", 4'b1001, 64'd3, 64'd5, 64'd11, 1});
`ifdef SEQ_ALU_MUL_EN
    vecs.push_back('{"mul_3x4", 4'b1010, 64'd3, 64'd4, 64'd12, XLEN + 1});
    vecs.push_back('{"mul_neg", 4'b1010, 64'd12, -64'sd3, -64'sd36, XLEN + 1});
`else
    vecs.push_back('{"c1010_slt", 4'b1010, 64'd3, 64'd4, 64'd1, 1});
    vecs.push_back('{"c1010_slt0", 4'b1010, 64'd12, -64'sd3, 64'd0, 1});
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    ctrl      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", XLEN'(in_ready), 64'd1);
    check("reset out_valid", XLEN'(out_valid), 64'd0);
    check("reset y", y, 64'd0);
    check("reset zero", XLEN'(zero), 64'd1);

    // out_ready while idle must be ignored.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("idle out_ready", XLEN'(out_valid), 64'd0);

    foreach (vecs[i]) do_check(vecs[i].name, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].y,
                               vecs[i].lat);

    // SLL shamt 3: in_ready low for exactly 4 cycles with out_ready held.
    @(negedge clk);
    out_ready = 1'b1;
    ctrl      = 4'b0011;
    a         = 64'd1;
    b         = 64'd67;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("sll busy cycles", XLEN'(n), 64'd4);

    // DONE hold with a competing request, then release and accept it.
    ctrl     = 4'b0010;
    a        = 64'd20;
    b        = 64'd22;
    in_valid = 1'b1;
    @(negedge clk);
    ctrl = 4'b0110;
    a    = 64'd1;
    b    = 64'd1;
    for (int k = 0; k < 5; k++) begin
      check("hold out_valid", XLEN'(out_valid), 64'd1);
      check("hold in_ready", XLEN'(in_ready), 64'd0);
      check("hold y", y, 64'd42);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release in_ready", XLEN'(in_ready), 64'd1);
    check("release out_valid", XLEN'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("next out_valid", XLEN'(out_valid), 64'd1);
    check("next y", y, 64'd0);
    check("next zero", XLEN'(zero), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Leave a nonzero result registered, then reset in the middle of a long shift.
    do_check("pre_rst add", 4'b0010, 64'd5, 64'd7, 64'd12, 1);
    ctrl     = 4'b0011;
    a        = 64'd1;
    b        = 64'd40;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid shift busy", XLEN'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst in_ready", XLEN'(in_ready), 64'd1);
    check("rst out_valid", XLEN'(out_valid), 64'd0);
    check("rst y", y, 64'd0);
    check("rst zero", XLEN'(zero), 64'd1);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("no stale result", XLEN'(n), 64'd0);

    // Randomized ops against the reference model.
    for (int k = 0; k < 40; k++) begin
      rc = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       begin ra = 64'($urandom_range(0, 20)); rb = 64'($urandom_range(0, 70)); end
        default: ;
      endcase
      do_check($sformatf("rand%0d c%0d", k, rc), rc, ra, rb, model_y(rc, ra, rb),
               model_lat(rc, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
